cpu_run_ctrl: RTL

Synthesizable run controller that sits between a host/loader and the pipelined CPU. It holds the CPU in reset and streams a program into instruction memory, then releases the CPU and counts cycles. It snoops data-memory writes to capture result words and detect a completion mailbox. It ends each run as DONE or TIMEOUT, with the cycle count held. This replaces the fixed program image, fixed cycle limit and `DM[2] != 0` completion check with a parametrised, re-runnable block.

---
 rtl/cpu_run_pkg.sv | 36 +++
 rtl/cpu_run_ctrl_result_capture.sv | 42 ++++
 rtl/cpu_run_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the CPU run controller.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    RC_IDLE,
    RC_LOAD,
    RC_RUN,
    RC_DONE,
    RC_TIMEOUT
  } rc_state_t;

  localparam int RC_MAX_CYCLES = 1401;
  localparam int RC_DONE_ADDR  = 2;
  localparam int RC_RES_BASE   = 1;
  localparam int RC_RES_WORDS  = 2;

  typedef struct packed {
    logic cpu_rst;
    logic ld_ready;
    logic busy;
    logic run_done;
    logic run_timeout;
  } rc_flags_t;

  // Status outputs as a pure function of the state being entered.
  function automatic rc_flags_t rc_flags(input rc_state_t s);
    rc_flags_t f;
    f.cpu_rst     = (s != RC_RUN);
    f.ld_ready    = (s == RC_LOAD);
    f.busy        = (s == RC_LOAD) || (s == RC_RUN);
    f.run_done    = (s == RC_DONE);
    f.run_timeout = (s == RC_TIMEOUT);
    return f;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_result_capture.sv
// Snoops data-memory writes into a small bank of result registers.
module run_result_capture
  import cpu_run_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DADDR_W   = 7,
  parameter int RES_BASE  = RC_RES_BASE,
  parameter int RES_WORDS = RC_RES_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          dm_we,
  input  logic [DADDR_W-1:0]            dm_addr,
  input  logic [DATA_W-1:0]             dm_wdata,
  output logic [RES_WORDS*DATA_W-1:0]   results
);

  genvar gi;
  generate
    for (gi = 0; gi < RES_WORDS; gi++) begin : g_word
      logic             hit;
      logic [DATA_W-1:0] word;

      assign hit = en && dm_we && (dm_addr == DADDR_W'(RES_BASE + gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word <= '0;
        end else if (clr) begin
          word <= '0;
        end else if (hit) begin
          word <= dm_wdata;
        end
      end

      assign results[gi*DATA_W +: DATA_W] = word;
    end
  endgenerate

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads instruction memory, runs the CPU, and ends each run as DONE or TIMEOUT.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IADDR_W    = 8,
  parameter int DADDR_W    = 7,
  parameter int MAX_CYCLES = RC_MAX_CYCLES,
  parameter int DONE_ADDR  = RC_DONE_ADDR,
  parameter int RES_BASE   = RC_RES_BASE,
  parameter int RES_WORDS  = RC_RES_WORDS,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        reload,
  input  logic                        clear,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [IADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  input  logic                        ld_last,
  output logic                        imem_we,
  output logic [IADDR_W-1:0]          imem_waddr,
  output logic [DATA_W-1:0]           imem_wdata,
  output logic                        cpu_rst,
  input  logic                        dm_we,
  input  logic [DADDR_W-1:0]          dm_addr,
  input  logic [DATA_W-1:0]           dm_wdata,
  output logic                        busy,
  output logic                        run_done,
  output logic                        run_timeout,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [RES_WORDS*DATA_W-1:0] results
);

  rc_state_t        state;
  rc_flags_t        flags;
  logic             last_pending;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             run_en;
  logic             res_clr;
  logic             done_hit;
  logic             budget_hit;
  logic             ld_fire;

  assign run_en     = (state == RC_RUN);
  assign res_clr    = (state == RC_IDLE) && start;
  assign done_hit   = dm_we && (dm_addr == DADDR_W'(DONE_ADDR)) && (dm_wdata != '0);
  assign budget_hit = (count == CNT_W'(MAX_CYCLES - 1));
  assign count_inc  = (&count) ? count : count + CNT_W'(1);
  assign ld_fire    = (state == RC_LOAD) && flags.ld_ready && ld_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RC_IDLE;
      flags        <= rc_flags(RC_IDLE);
      last_pending <= 1'b0;
      count        <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        RC_IDLE: begin
          if (start) begin
            count        <= '0;
            last_pending <= 1'b0;
            if (reload) begin
              state <= RC_LOAD;
              flags <= rc_flags(RC_LOAD);
            end else begin
              state <= RC_RUN;
              flags <= rc_flags(RC_RUN);
            end
          end
        end
        RC_LOAD: begin
          if (ld_fire) begin
            imem_we    <= 1'b1;
            imem_waddr <= ld_addr;
            imem_wdata <= ld_data;
            // Stop accepting after the last word; release the CPU only once that write has issued.
            if (ld_last) begin
              last_pending   <= 1'b1;
              flags.ld_ready <= 1'b0;
            end
          end
          if (last_pending) begin
            last_pending <= 1'b0;
            state        <= RC_RUN;
            flags        <= rc_flags(RC_RUN);
          end
        end
        RC_RUN: begin
          count <= count_inc;
          if (done_hit) begin
            state <= RC_DONE;
            flags <= rc_flags(RC_DONE);
          end else if (budget_hit) begin
            state <= RC_TIMEOUT;
            flags <= rc_flags(RC_TIMEOUT);
          end
        end
        RC_DONE, RC_TIMEOUT: begin
          if (clear) begin
            state <= RC_IDLE;
            flags <= rc_flags(RC_IDLE);
          end
        end
        default: begin
          state <= RC_IDLE;
          flags <= rc_flags(RC_IDLE);
        end
      endcase
    end
  end

  assign cpu_rst     = flags.cpu_rst;
  assign ld_ready    = flags.ld_ready;
  assign busy        = flags.busy;
  assign run_done    = flags.run_done;
  assign run_timeout = flags.run_timeout;
  assign cycle_count = count;

  run_result_capture #(
    .DATA_W    (DATA_W),
    .DADDR_W   (DADDR_W),
    .RES_BASE  (RES_BASE),
    .RES_WORDS (RES_WORDS)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .clr      (res_clr),
    .en       (run_en),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .results  (results)
  );

endmodule
